// File: rtl/div_unit.sv
// div_unit: iterative restoring divider (one quotient bit per cycle) for the
// mini-MIPS HI/LO path. Signed (DIV) or unsigned (DIVU) operands; quotient
// goes to LO, remainder to HI. Divide-by-zero and signed overflow return
// forced results with a flag.
//
// Build option: DIV_EARLY_OUT_EN -- when defined, the special cases are
// caught in IDLE and finished one cycle after start without running the loop.
//
// state | meaning
// IDLE  | waiting for start, outputs hold the last result
// RUN   | shift-subtract loop, one quotient bit per cycle
// FIX   | sign correction / special-case forcing, results written, done pulse
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem,
    output logic             div_zero,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state, state_nxt;
    logic [5:0]       cnt, cnt_nxt;
    logic [WIDTH-1:0] dvd, dvd_nxt;
    logic [WIDTH-1:0] dsr, dsr_nxt;
    logic [WIDTH-1:0] a_lat, a_lat_nxt;
    logic [WIDTH:0]   prem, prem_nxt;
    logic             neg_q, neg_q_nxt;
    logic             neg_r, neg_r_nxt;
    logic             dz_lat, dz_lat_nxt;
    logic             ov_lat, ov_lat_nxt;
    logic             done_nxt;
    logic [WIDTH-1:0] quo_nxt, rem_nxt;
    logic             div_zero_nxt, overflow_nxt;

    logic             a_neg, b_neg, in_dz, in_ov;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH+1:0] shifted, trial;
    logic [WIDTH-1:0] q_fix, r_fix;

    // Operand magnitudes and special-case detection on the live inputs
    assign a_neg = is_signed & A[WIDTH-1];
    assign b_neg = is_signed & B[WIDTH-1];
    assign a_mag = a_neg ? -A : A;
    assign b_mag = b_neg ? -B : B;
    assign in_dz = (B == '0);
    assign in_ov = is_signed & (A == MIN_NEG) & (B == '1);

    // One restoring step: the partial remainder is always below the divisor,
    // so the top bit of shifted is zero and trial's MSB is a clean sign bit.
    assign shifted = {prem, dvd[WIDTH-1]};
    assign trial   = shifted - {2'b00, dsr};

    assign q_fix = neg_q ? -dvd : dvd;
    assign r_fix = neg_r ? -prem[WIDTH-1:0] : prem[WIDTH-1:0];

    assign busy = (state != IDLE);

    // Next-state and datapath update
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        dvd_nxt      = dvd;
        dsr_nxt      = dsr;
        a_lat_nxt    = a_lat;
        prem_nxt     = prem;
        neg_q_nxt    = neg_q;
        neg_r_nxt    = neg_r;
        dz_lat_nxt   = dz_lat;
        ov_lat_nxt   = ov_lat;
        done_nxt     = 1'b0;
        quo_nxt      = quo;
        rem_nxt      = rem;
        div_zero_nxt = div_zero;
        overflow_nxt = overflow;

        case (state)
            IDLE: begin
                if (start) begin
`ifdef DIV_EARLY_OUT_EN
                    if (in_dz || in_ov) begin
                        done_nxt     = 1'b1;
                        quo_nxt      = in_dz ? '1 : MIN_NEG;
                        rem_nxt      = in_dz ? A : '0;
                        div_zero_nxt = in_dz;
                        overflow_nxt = in_ov & ~in_dz;
                    end else begin
`else
                    begin
`endif
                        state_nxt  = RUN;
                        cnt_nxt    = '0;
                        dvd_nxt    = a_mag;
                        dsr_nxt    = b_mag;
                        a_lat_nxt  = A;
                        prem_nxt   = '0;
                        neg_q_nxt  = a_neg ^ b_neg;
                        neg_r_nxt  = a_neg;
                        dz_lat_nxt = in_dz;
                        ov_lat_nxt = in_ov;
                    end
                end
            end

            RUN: begin
                if (!trial[WIDTH+1]) begin
                    prem_nxt = trial[WIDTH:0];
                    dvd_nxt  = {dvd[WIDTH-2:0], 1'b1};
                end else begin
                    prem_nxt = shifted[WIDTH:0];
                    dvd_nxt  = {dvd[WIDTH-2:0], 1'b0};
                end
                cnt_nxt = cnt + 6'd1;
                if (cnt == 6'(WIDTH-1))
                    state_nxt = FIX;
            end

            FIX: begin
                done_nxt  = 1'b1;
                state_nxt = IDLE;
                if (dz_lat) begin
                    quo_nxt      = '1;
                    rem_nxt      = a_lat;
                    div_zero_nxt = 1'b1;
                    overflow_nxt = 1'b0;
                end else if (ov_lat) begin
                    quo_nxt      = MIN_NEG;
                    rem_nxt      = '0;
                    div_zero_nxt = 1'b0;
                    overflow_nxt = 1'b1;
                end else begin
                    quo_nxt      = q_fix;
                    rem_nxt      = r_fix;
                    div_zero_nxt = 1'b0;
                    overflow_nxt = 1'b0;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    // State and datapath registers, cleared by asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            dvd      <= '0;
            dsr      <= '0;
            a_lat    <= '0;
            prem     <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dz_lat   <= 1'b0;
            ov_lat   <= 1'b0;
            done     <= 1'b0;
            quo      <= '0;
            rem      <= '0;
            div_zero <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            dvd      <= dvd_nxt;
            dsr      <= dsr_nxt;
            a_lat    <= a_lat_nxt;
            prem     <= prem_nxt;
            neg_q    <= neg_q_nxt;
            neg_r    <= neg_r_nxt;
            dz_lat   <= dz_lat_nxt;
            ov_lat   <= ov_lat_nxt;
            done     <= done_nxt;
            quo      <= quo_nxt;
            rem      <= rem_nxt;
            div_zero <= div_zero_nxt;
            overflow <= overflow_nxt;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed and randomized checks of div_unit against a plain
// arithmetic model of MIPS DIV/DIVU including the forced special cases.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        busy, done, div_zero, overflow;
    logic [31:0] quo, rem;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int c0 = 0;
    int done_cnt = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
        .A(A), .B(B), .busy(busy), .done(done), .quo(quo), .rem(rem),
        .div_zero(div_zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: MIPS DIV/DIVU semantics with the forced special-case results
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic dz, output logic ov);
        int sa, sb;
        dz = 1'b0;
        ov = 1'b0;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a; dz = 1'b1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 32'd0; ov = 1'b1;
        end else if (s) begin
            sa = a; sb = b;
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // Called at a negedge: present the operation and pass the start edge
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
        start = 1'b1; A = a; B = b; is_signed = s;
        @(posedge clk);
        #1;
        c0 = cyc;
        start = 1'b0;
        A = $urandom; B = $urandom; is_signed = 1'($urandom);
    endtask

    // Wait (bounded) for done and compare latency, results and flags
    task automatic wait_check(input logic [31:0] a, input logic [31:0] b, input logic s,
                              input string tag);
        logic [31:0] q, r;
        logic dz, ov;
        int exp_lat;
        int lat;
        model(a, b, s, q, r, dz, ov);
        exp_lat = 33;
`ifdef DIV_EARLY_OUT_EN
        if (dz || ov) exp_lat = 1;
`endif
        lat = 0;
        do begin
            @(negedge clk);
            lat = cyc - c0;
            if (lat == 1) chk({tag, ".busy_after_start"}, 32'(busy), (exp_lat == 1) ? 32'd0 : 32'd1);
        end while (!done && lat < 40);
        chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, ".quo"}, quo, q);
        chk({tag, ".rem"}, rem, r);
        chk({tag, ".div_zero"}, 32'(div_zero), 32'(dz));
        chk({tag, ".overflow"}, 32'(overflow), 32'(ov));
        chk({tag, ".busy_at_done"}, 32'(busy), 32'd0);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input string tag);
        @(negedge clk);
        issue(a, b, s);
        wait_check(a, b, s, tag);
        @(negedge clk);
        chk({tag, ".done_one_cycle"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        int          dc0;

        // Reset state
        #1;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.quo", quo, 32'd0);
        chk("rst.rem", rem, 32'd0);
        chk("rst.flags", {30'd0, div_zero, overflow}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle.no_done", 32'(done_cnt), 32'd0);

        // Directed cases
        run_op(32'd100, 32'd7, 1'b0, "u100_7");
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, "s-7_2");
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, "umax_1");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "s_ovf");
        run_op(32'h8000_0000, 32'd0, 1'b1, "s_dz");
        run_op(32'd12345, 32'd0, 1'b0, "u_dz");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "u_min_max");
        run_op(32'd7, 32'hFFFF_FFF9, 1'b1, "s7_-7");
        run_op(32'd5, 32'd9, 1'b0, "u_small");

        // start while busy is ignored: first result only, single done
        @(negedge clk);
        dc0 = done_cnt;
        issue(32'd100, 32'd7, 1'b0);
        while (cyc < c0 + 10) @(negedge clk);
        start = 1'b1; A = 32'd50; B = 32'd5; is_signed = 1'b0;
        @(negedge clk);
        start = 1'b0;
        wait_check(32'd100, 32'd7, 1'b0, "busy_start_ignored");
        repeat (40) @(negedge clk);
        chk("busy_start.single_done", 32'(done_cnt - dc0), 32'd1);

        // start in the done cycle is accepted
        @(negedge clk);
        issue(32'd1000, 32'd33, 1'b0);
        wait_check(32'd1000, 32'd33, 1'b0, "b2b_first");
        issue(32'hFFFF_FC18, 32'd33, 1'b1);
        wait_check(32'hFFFF_FC18, 32'd33, 1'b1, "b2b_second");

        // Reset mid-operation
        @(negedge clk);
        dc0 = done_cnt;
        issue(32'd100, 32'd7, 1'b0);
        while (cyc < c0 + 10) @(negedge clk);
        start = 1'b1; A = 32'd50; B = 32'd5;
        @(negedge clk);
        start = 1'b0;
        while (cyc < c0 + 20) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst.busy", 32'(busy), 32'd0);
        chk("midrst.quo", quo, 32'd0);
        chk("midrst.rem", rem, 32'd0);
        chk("midrst.flags", {30'd0, div_zero, overflow}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("midrst.no_done", 32'(done_cnt - dc0), 32'd0);
        chk("midrst.quo_hold", quo, 32'd0);
        run_op(32'd50, 32'd5, 1'b0, "after_rst");

        // Randomized operations, biased toward boundary operands
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            rs = 1'($urandom);
            case ($urandom_range(0, 9))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; rs = 1'b1; end
                2: rb = 32'd1;
                3: rb = 32'hFFFF_FFFF;
                4: ra = 32'h8000_0000;
                default: ;
            endcase
            run_op(ra, rb, rs, $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-bit integer divider for the mini-MIPS datapath, the inverse counterpart of the ALU's single-cycle MUL/MULU path. It accepts signed (DIV) or unsigned (DIVU) operands, runs a restoring shift-subtract loop at one quotient bit per cycle, and returns the quotient for LO and the remainder for HI. The pipeline stalls on `busy` and writes HI/LO when `done` pulses.

## Interface
- `WIDTH`, 32, operand/result width; the iteration count equals `WIDTH`.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `is_signed`  in  1  1 = two's-complement divide, 0 = unsigned; captured with `start`.
- `A`  in  WIDTH  dividend; captured with `start`.
- `B`  in  WIDTH  divisor; captured with `start`.
- `busy`  out  1  high while a division is in progress.
- `done`  out  1  one-cycle completion pulse.
- `quo`  out  WIDTH  quotient (to LO); holds until the next completion.
- `rem`  out  WIDTH  remainder (to HI); holds until the next completion.
- `div_zero`  out  1  last completed operation had `B == 0`.
- `overflow`  out  1  last completed operation was signed `0x80000000 / 0xFFFFFFFF`.

## Operation
- States:
  - IDLE: `busy=0`.
  - RUN: `busy=1`; 6-bit counter runs 0..WIDTH-1.
  - FIX: `busy=1`; sign correction and output write.
- Exit to IDLE from FIX, or from IDLE directly in the early-out case (see Configuration).
- IDLE + `start`:
  - Latch `is_signed`.
  - Latch neg_q = signed & (A[31]^B[31]) and neg_r = signed & A[31].
  - Load |A| into the dividend shift register and |B| into the divisor register; magnitude is taken only when `is_signed`.
  - Clear the partial remainder (WIDTH+1 bits) and the counter.
  - Go to RUN.
- RUN, each cycle:
  - Shift {rem, dvd} left by one.
  - Trial = rem − divisor.
  - If trial is non-negative: rem = trial and quotient bit = 1; otherwise keep rem and quotient bit = 0.
  - After the WIDTH-th iteration, go to FIX.
- FIX:
  - `quo` = neg_q ? −q : q.
  - `rem` = neg_r ? −r : r.
  - `div_zero=0`, `overflow=0`, `done=1`.
  - Go to IDLE.
- Divide by zero:
  - The loop naturally yields q = all ones and r = |A|. After sign fixup, required results are `quo=0xFFFFFFFF` (unsigned), or ±1-style fixup is **not** applied: force `quo=0xFFFFFFFF`, `rem=A` in both modes.
  - `div_zero=1`.
- Signed overflow (`0x80000000 / −1`): force `quo=0x80000000`, `rem=0`, `overflow=1`.
- `start` while `busy`: ignored; no queuing.
- `start` in the same cycle as `done`: accepted, because the state is already IDLE.
- Operand inputs may change freely after the capture cycle.

## Timing
- Reset values: state IDLE, `busy=0`, `done=0`, `quo=0`, `rem=0`, `div_zero=0`, `overflow=0`, internal registers 0.
- `start` sampled at edge N:
  - `busy` goes high after edge N.
  - RUN covers edges N+1..N+32; FIX is the cycle after edge N+32.
  - `done`, `quo`, `rem` and the flags update at edge N+33; `busy` falls at the same edge.
- Normal latency: 33 cycles, start edge to done edge.
- `done` is high for exactly one cycle and is never asserted without a preceding accepted `start`.
- `rst` mid-operation: immediate return to IDLE, all outputs cleared, no `done` pulse.

## Configuration
- `DIV_EARLY_OUT_EN` defined:
  - In IDLE, divide-by-zero and signed overflow are detected combinationally on `A`/`B`/`is_signed`.
  - Forced results, flag and `done` are written at edge N+1, without entering RUN.
  - `busy` stays 0.
- Not defined:
  - Every operation takes the full 33 cycles.
  - The special cases are detected on the latched operands and forced in FIX.
  - Results and flags are identical to the defined case; only latency differs.

## Test plan
- Unsigned `A=100`, `B=7` -> `done` 33 cycles after start; `quo=14`, `rem=2`; both flags 0.
- Signed `A=0xFFFFFFF9` (−7), `B=2` -> `quo=0xFFFFFFFD`, `rem=0xFFFFFFFF`.
- Unsigned `A=0xFFFFFFFF`, `B=1` -> `quo=0xFFFFFFFF`, `rem=0`.
- Signed `A=0x80000000`, `B=0xFFFFFFFF` -> `quo=0x80000000`, `rem=0`, `overflow=1`.
- Signed `A=0x80000000`, `B=0` -> `quo=0xFFFFFFFF`, `rem=0x80000000`, `div_zero=1`. Latency is 1 cycle with `DIV_EARLY_OUT_EN`, 33 cycles without.
- Start 100/7; pulse `start` with 50/5 at cycle 10; assert `rst` at cycle 20 -> second start ignored, no `done`, outputs 0. Then 50/5 issued after reset -> `quo=10`, `rem=0` at 33 cycles.
